// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared defaults for the scoreboarded register file and the helper that
//   derives the register address width from the register count.
//   No ports; imported by regfile_scoreboard and regfile_sb.
package regfile_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;

  // Address width for a register file of nreg entries (nreg is a power of two).
  function automatic int addr_width(input int nreg);
    return $clog2(nreg);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Pending-write scoreboard: one bit per architectural register, set when the
//   issue stage reserves a destination and cleared when writeback lands.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     wr_en, wr_addr       writeback strobe / destination (clears pend)
//     alloc_en, alloc_addr reservation strobe / destination (sets pend)
//     flush                clears every pending bit, beats a same-cycle alloc
//     pend                 pending vector, bit 0 is always 0
//     pend_cnt             registered population count of pend
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  localparam int AW  = addr_width(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_addr,
  input  logic            flush,
  output logic [NREG-1:0] pend,
  output logic [AW:0]     pend_cnt
);

  logic [NREG-1:0] pend_nxt;
  logic [AW:0]     cnt_nxt;

  // Priority, lowest to highest: writeback clear, new reservation, flush.
  // A reservation landing with its own writeback therefore stays pending.
  always_comb begin
    pend_nxt = pend;
    if (wr_en)    pend_nxt[wr_addr]    = 1'b0;
    if (alloc_en) pend_nxt[alloc_addr] = 1'b1;
    if (flush)    pend_nxt             = '0;
    pend_nxt[0] = 1'b0;
  end

  // Count the next vector so pend_cnt moves on the same edge as pend.
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(pend_nxt[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend     <= '0;
      pend_cnt <= '0;
    end else begin
      pend     <= pend_nxt;
      pend_cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
//   Register file with NRD combinational read ports, one write port and a
//   pending-write scoreboard. Register 0 is hard-wired to zero.
//   Strobes (wr_en, alloc_en, flush) are single-cycle qualifiers sampled on
//   the rising clk edge; there is no back-pressure.
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     rd_addr  [NRD*AW]    read addresses, port i at [i*AW +: AW]
//     rd_data  [NRD*XLEN]  read data, port i at [i*XLEN +: XLEN]
//     rd_busy  [NRD]       port i source has a pending write
//     wr_en/wr_addr/wr_data  writeback
//     alloc_en/alloc_addr  destination reservation
//     flush                clear all pending bits
//     pend_cnt [AW+1]      number of pending registers
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREG   = NREG_DEFAULT,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = addr_width(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic [AW:0]         pend_cnt
);

  localparam bit FWD = (BYPASS != 0);

  logic [XLEN-1:0] mem [NREG];
  logic [NREG-1:0] pend;
  logic            wr_live;
  logic            alloc_live;

  // Writes and reservations aimed at x0 are dropped at the source.
  assign wr_live    = wr_en && (wr_addr != '0);
  assign alloc_live = alloc_en && (alloc_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_live) begin
      mem[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NREG(NREG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_live),
    .wr_addr   (wr_addr),
    .alloc_en  (alloc_live),
    .alloc_addr(alloc_addr),
    .flush     (flush),
    .pend      (pend),
    .pend_cnt  (pend_cnt)
  );

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic          hit;

    assign ra  = rd_addr[g*AW +: AW];
    // Forwarded write: the value is in flight, so the source is not busy.
    assign hit = FWD && wr_live && (wr_addr == ra);

    assign rd_data[g*XLEN +: XLEN] = (ra == '0) ? '0 :
                                     hit        ? wr_data : mem[ra];
    assign rd_busy[g] = (ra != '0) && !hit && pend[ra];
  end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
  logic [NRD-1:0]      rd_busy_b, rd_busy_n;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [XLEN-1:0]     wr_data;
  logic                alloc_en;
  logic [AW-1:0]       alloc_addr;
  logic                flush;
  logic [AW:0]         pend_cnt_b, pend_cnt_n;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: architectural register values and reservation flags.
  logic [XLEN-1:0] model_mem  [NREG];
  bit              model_pend [NREG];

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
    .pend_cnt(pend_cnt_b));

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .BYPASS(0)) dut_nobyp (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .flush(flush),
    .pend_cnt(pend_cnt_n));

  // ---------------- model ----------------
  function automatic logic [XLEN-1:0] exp_data(input int a, input bit byp);
    if (a == 0) return '0;
    if (byp && wr_en && int'(wr_addr) == a) return wr_data;
    return model_mem[a];
  endfunction

  function automatic bit exp_busy(input int a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && wr_en && int'(wr_addr) == a) return 1'b0;
    return model_pend[a];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int r = 0; r < NREG; r++) c += int'(model_pend[r]);
    return c;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      model_mem[r]  = '0;
      model_pend[r] = 1'b0;
    end
  endtask

  // Architectural effect of one clock edge given the inputs presented.
  task automatic model_edge();
    bit                wr_hit;
    logic [XLEN-1:0]   wd;
    int                wa, aa;
    wa = int'(wr_addr);
    aa = int'(alloc_addr);
    wd = wr_data;
    wr_hit = wr_en && wa != 0;
    for (int r = 1; r < NREG; r++) begin
      if (flush)                          model_pend[r] = 1'b0;
      else if (alloc_en && r == aa)       model_pend[r] = 1'b1;
      else if (wr_hit && r == wa)         model_pend[r] = 1'b0;
    end
    if (wr_hit) model_mem[wa] = wd;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  // Advance one edge; returns 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    #1;
  endtask

  function automatic int rand_addr();
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 7));
    return int'($urandom_range(0, NREG - 1));
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    set_rd(0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int a = 0; a < NREG; a++) begin
      set_rd(a, a);
      #2;
      for (int p = 0; p < NRD; p++) begin
        n_cmp += 4;
        if (rd_data_b[p*XLEN +: XLEN] !== '0) begin
          n_fail++; $display("FAIL reset_data_byp a=%0d p=%0d got %h want 0", a, p, rd_data_b[p*XLEN +: XLEN]);
        end
        if (rd_data_n[p*XLEN +: XLEN] !== '0) begin
          n_fail++; $display("FAIL reset_data_nobyp a=%0d p=%0d got %h want 0", a, p, rd_data_n[p*XLEN +: XLEN]);
        end
        if (rd_busy_b[p] !== 1'b0) begin
          n_fail++; $display("FAIL reset_busy_byp a=%0d p=%0d got %b want 0", a, p, rd_busy_b[p]);
        end
        if (rd_busy_n[p] !== 1'b0) begin
          n_fail++; $display("FAIL reset_busy_nobyp a=%0d p=%0d got %b want 0", a, p, rd_busy_n[p]);
        end
      end
      tick();
    end
    n_cmp += 2;
    if (pend_cnt_b !== '0) begin
      n_fail++; $display("FAIL reset_cnt_byp got %0d want 0", pend_cnt_b);
    end
    if (pend_cnt_n !== '0) begin
      n_fail++; $display("FAIL reset_cnt_nobyp got %0d want 0", pend_cnt_n);
    end
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    set_rd(5, 0);
    #2;
    n_cmp += 3;
    if (rd_data_b[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_same_cycle got %h want deadbeef", rd_data_b[31:0]);
    end
    if (rd_busy_b[0] !== 1'b0) begin
      n_fail++; $display("FAIL bypass_busy got %b want 0", rd_busy_b[0]);
    end
    if (rd_data_n[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL nobypass_old_value got %h want 0", rd_data_n[31:0]);
    end
    tick();
    drive_idle();
    #2;
    n_cmp += 2;
    if (rd_data_n[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL nobypass_next_cycle got %h want deadbeef", rd_data_n[31:0]);
    end
    if (rd_data_b[31:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_stored got %h want deadbeef", rd_data_b[31:0]);
    end
    tick();
  endtask

  task automatic test_x0();
    wr_en = 1'b1; wr_addr = '0; wr_data = 32'h12345678;
    alloc_en = 1'b1; alloc_addr = '0;
    set_rd(0, 0);
    #2;
    n_cmp += 2;
    if (rd_data_b[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL x0_no_forward got %h want 0", rd_data_b[63:32]);
    end
    if (rd_busy_b[0] !== 1'b0) begin
      n_fail++; $display("FAIL x0_busy_same got %b want 0", rd_busy_b[0]);
    end
    tick();
    drive_idle();
    #1;
    n_cmp += 4;
    if (rd_data_b[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL x0_read_byp got %h want 0", rd_data_b[31:0]);
    end
    if (rd_data_n[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL x0_read_nobyp got %h want 0", rd_data_n[31:0]);
    end
    if (rd_busy_n[0] !== 1'b0) begin
      n_fail++; $display("FAIL x0_busy_after got %b want 0", rd_busy_n[0]);
    end
    if (pend_cnt_b !== '0) begin
      n_fail++; $display("FAIL x0_cnt got %0d want 0", pend_cnt_b);
    end
    tick();
  endtask

  task automatic test_alloc_count();
    int addrs [3] = '{3, 7, 9};
    for (int k = 0; k < 3; k++) begin
      alloc_en = 1'b1; alloc_addr = AW'(addrs[k]);
      tick();
      n_cmp += 2;
      if (pend_cnt_b !== (AW+1)'(k + 1)) begin
        n_fail++; $display("FAIL alloc_cnt_byp step=%0d got %0d want %0d", k, pend_cnt_b, k + 1);
      end
      if (pend_cnt_n !== (AW+1)'(k + 1)) begin
        n_fail++; $display("FAIL alloc_cnt_nobyp step=%0d got %0d want %0d", k, pend_cnt_n, k + 1);
      end
    end
    drive_idle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h00000777;
    set_rd(7, 3);
    #2;
    n_cmp += 3;
    if (rd_busy_b[0] !== 1'b0) begin
      n_fail++; $display("FAIL write_pending_fwd_busy got %b want 0", rd_busy_b[0]);
    end
    if (rd_busy_n[0] !== 1'b1) begin
      n_fail++; $display("FAIL write_pending_preedge_busy got %b want 1", rd_busy_n[0]);
    end
    if (rd_busy_b[1] !== 1'b1) begin
      n_fail++; $display("FAIL x3_busy got %b want 1", rd_busy_b[1]);
    end
    tick();
    drive_idle();
    #1;
    n_cmp += 3;
    if (pend_cnt_b !== 6'd2) begin
      n_fail++; $display("FAIL write_clears_cnt got %0d want 2", pend_cnt_b);
    end
    if (rd_busy_n[0] !== 1'b0) begin
      n_fail++; $display("FAIL x7_busy_after got %b want 0", rd_busy_n[0]);
    end
    if (rd_data_n[31:0] !== 32'h00000777) begin
      n_fail++; $display("FAIL x7_data got %h want 00000777", rd_data_n[31:0]);
    end
    tick();
  endtask

  task automatic test_alloc_write_same();
    alloc_en = 1'b1; alloc_addr = 5'd4;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hA5;
    set_rd(4, 9);
    tick();
    drive_idle();
    #1;
    n_cmp += 4;
    if (pend_cnt_b !== 6'd3) begin
      n_fail++; $display("FAIL same_cnt got %0d want 3", pend_cnt_b);
    end
    if (rd_data_b[31:0] !== 32'hA5) begin
      n_fail++; $display("FAIL same_data got %h want a5", rd_data_b[31:0]);
    end
    if (rd_busy_b[0] !== 1'b1) begin
      n_fail++; $display("FAIL same_busy_byp got %b want 1", rd_busy_b[0]);
    end
    if (rd_busy_n[0] !== 1'b1) begin
      n_fail++; $display("FAIL same_busy_nobyp got %b want 1", rd_busy_n[0]);
    end
    tick();
    alloc_en = 1'b1; alloc_addr = 5'd4;
    tick();
    drive_idle();
    n_cmp += 1;
    if (pend_cnt_n !== 6'd3) begin
      n_fail++; $display("FAIL realloc_cnt got %0d want 3", pend_cnt_n);
    end
  endtask

  task automatic test_flush();
    flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd2;
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h88;
    tick();
    drive_idle();
    set_rd(2, 8);
    #1;
    n_cmp += 5;
    if (pend_cnt_b !== '0) begin
      n_fail++; $display("FAIL flush_cnt_byp got %0d want 0", pend_cnt_b);
    end
    if (pend_cnt_n !== '0) begin
      n_fail++; $display("FAIL flush_cnt_nobyp got %0d want 0", pend_cnt_n);
    end
    if (rd_busy_b[0] !== 1'b0) begin
      n_fail++; $display("FAIL flush_x2_busy got %b want 0", rd_busy_b[0]);
    end
    if (rd_data_n[63:32] !== 32'h88) begin
      n_fail++; $display("FAIL flush_write_data got %h want 88", rd_data_n[63:32]);
    end
    set_rd(3, 4);
    #1;
    if (rd_busy_n !== 2'b00) begin
      n_fail++; $display("FAIL flush_old_busy got %b want 00", rd_busy_n);
    end
    tick();
  endtask

  task automatic test_reset_mid_write();
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h1;
    alloc_en = 1'b1; alloc_addr = 5'd6;
    set_rd(6, 5);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive_idle();
    #1;
    n_cmp += 4;
    if (rd_data_b[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_x6_byp got %h want 0", rd_data_b[31:0]);
    end
    if (rd_data_n[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_x6_nobyp got %h want 0", rd_data_n[31:0]);
    end
    if (rd_data_b[63:32] !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_x5 got %h want 0", rd_data_b[63:32]);
    end
    if (pend_cnt_b !== '0) begin
      n_fail++; $display("FAIL rst_mid_cnt got %0d want 0", pend_cnt_b);
    end
    tick();
  endtask

  task automatic test_random();
    int a;
    rst = 1'b1;
    drive_idle();
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int c = 0; c < 400; c++) begin
      wr_en      = ($urandom_range(0, 1) == 1);
      wr_addr    = AW'(rand_addr());
      wr_data    = $urandom;
      alloc_en   = ($urandom_range(0, 2) != 0);
      alloc_addr = AW'(rand_addr());
      flush      = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) set_rd(int'(wr_addr), rand_addr());
      else                           set_rd(rand_addr(), int'(alloc_addr));
      #2;
      for (int p = 0; p < NRD; p++) begin
        a = int'(rd_addr[p*AW +: AW]);
        n_cmp += 4;
        if (rd_data_b[p*XLEN +: XLEN] !== exp_data(a, 1'b1)) begin
          n_fail++; $display("FAIL rand_data_byp c=%0d p=%0d a=%0d got %h want %h", c, p, a, rd_data_b[p*XLEN +: XLEN], exp_data(a, 1'b1));
        end
        if (rd_data_n[p*XLEN +: XLEN] !== exp_data(a, 1'b0)) begin
          n_fail++; $display("FAIL rand_data_nobyp c=%0d p=%0d a=%0d got %h want %h", c, p, a, rd_data_n[p*XLEN +: XLEN], exp_data(a, 1'b0));
        end
        if (rd_busy_b[p] !== exp_busy(a, 1'b1)) begin
          n_fail++; $display("FAIL rand_busy_byp c=%0d p=%0d a=%0d got %b want %b", c, p, a, rd_busy_b[p], exp_busy(a, 1'b1));
        end
        if (rd_busy_n[p] !== exp_busy(a, 1'b0)) begin
          n_fail++; $display("FAIL rand_busy_nobyp c=%0d p=%0d a=%0d got %b want %b", c, p, a, rd_busy_n[p], exp_busy(a, 1'b0));
        end
      end
      tick();
      n_cmp += 2;
      if (pend_cnt_b !== (AW+1)'(exp_cnt())) begin
        n_fail++; $display("FAIL rand_cnt_byp c=%0d got %0d want %0d", c, pend_cnt_b, exp_cnt());
      end
      if (pend_cnt_n !== (AW+1)'(exp_cnt())) begin
        n_fail++; $display("FAIL rand_cnt_nobyp c=%0d got %0d want %0d", c, pend_cnt_n, exp_cnt());
      end
    end
    drive_idle();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    set_rd(0, 0);
    model_reset();
    test_reset();
    test_bypass();
    test_x0();
    test_alloc_count();
    test_alloc_write_same();
    test_flush();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
